// File: rtl/inflight_tag_table.sv
// In-flight tag bookkeeping: allocates tags from tag_queue, keeps per-tag metadata, retires tagged responses.
// Optional allocation checker enabled by defining INFLIGHT_TAG_TABLE_CHECK_EN.
module inflight_tag_table #(
    parameter int NumTags   = 16,
    parameter int MetaWidth = 8,
    parameter int DataWidth = 32,
    parameter int TagWidth  = $clog2(NumTags)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    output logic                         tq_get_o,
    input  logic                         tq_valid_i,
    input  logic [TagWidth-1:0]          tq_tag_i,
    output logic                         tq_free_o,
    output logic [TagWidth-1:0]          tq_tag_o,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [MetaWidth-1:0]         req_meta_i,
    input  logic [DataWidth-1:0]         req_data_i,
    output logic                         iss_valid_o,
    input  logic                         iss_ready_i,
    output logic [TagWidth-1:0]          iss_tag_o,
    output logic [DataWidth-1:0]         iss_data_o,
    input  logic                         rsp_valid_i,
    output logic                         rsp_ready_o,
    input  logic [TagWidth-1:0]          rsp_tag_i,
    input  logic [DataWidth-1:0]         rsp_data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [MetaWidth-1:0]         out_meta_o,
    output logic [DataWidth-1:0]         out_data_o,
    output logic [$clog2(NumTags+1)-1:0] inflight_o,
    output logic                         err_o
);

    localparam int CntWidth = $clog2(NumTags + 1);

    logic                 iss_valid_q, iss_valid_d;
    logic [TagWidth-1:0]  iss_tag_q, iss_tag_d;
    logic [DataWidth-1:0] iss_data_q, iss_data_d;
    logic                 out_valid_q, out_valid_d;
    logic [MetaWidth-1:0] out_meta_q, out_meta_d;
    logic [DataWidth-1:0] out_data_q, out_data_d;
    logic [TagWidth-1:0]  out_tag_q, out_tag_d;
    logic [CntWidth-1:0]  inflight_q, inflight_d;
    logic [MetaWidth-1:0] meta_q [NumTags];
    logic [MetaWidth-1:0] meta_d [NumTags];
    logic                 rsp_acc;

    assign req_ready_o = tq_valid_i && (!iss_valid_q || iss_ready_i);
    assign tq_get_o    = req_valid_i && req_ready_o;
    assign rsp_ready_o = !out_valid_q || out_ready_i;
    assign rsp_acc     = rsp_valid_i && rsp_ready_o;
    assign tq_free_o   = out_valid_q && out_ready_i;
    assign tq_tag_o    = out_tag_q;

    assign iss_valid_o = iss_valid_q;
    assign iss_tag_o   = iss_tag_q;
    assign iss_data_o  = iss_data_q;
    assign out_valid_o = out_valid_q;
    assign out_meta_o  = out_meta_q;
    assign out_data_o  = out_data_q;
    assign inflight_o  = inflight_q;

    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_tag_d   = iss_tag_q;
        iss_data_d  = iss_data_q;
        out_valid_d = out_valid_q;
        out_meta_d  = out_meta_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        inflight_d  = inflight_q;
        meta_d      = meta_q;

        if (tq_get_o) begin
            iss_valid_d         = 1'b1;
            iss_tag_d           = tq_tag_i;
            iss_data_d          = req_data_i;
            meta_d[tq_tag_i]    = req_meta_i;
        end else if (iss_ready_i) begin
            iss_valid_d = 1'b0;
        end

        // Lookup reads the pre-write table; a same-cycle alloc of the responding tag is illegal.
        if (rsp_acc) begin
            out_valid_d = 1'b1;
            out_meta_d  = meta_q[rsp_tag_i];
            out_data_d  = rsp_data_i;
            out_tag_d   = rsp_tag_i;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end

        case ({tq_get_o, tq_free_o})
            2'b10:   inflight_d = inflight_q + CntWidth'(1);
            2'b01:   inflight_d = inflight_q - CntWidth'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            iss_valid_q <= 1'b0;
            iss_tag_q   <= '0;
            iss_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_meta_q  <= '0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            inflight_q  <= '0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_tag_q   <= iss_tag_d;
            iss_data_q  <= iss_data_d;
            out_valid_q <= out_valid_d;
            out_meta_q  <= out_meta_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            inflight_q  <= inflight_d;
        end
    end

    always_ff @(posedge clk_i) begin
        meta_q <= meta_d;
    end

`ifdef INFLIGHT_TAG_TABLE_CHECK_EN
    logic [NumTags-1:0] alloc_q, alloc_d;
    logic               err_q, err_d;

    always_comb begin
        alloc_d = alloc_q;
        err_d   = err_q;
        // Re-allocating a tag that is being freed in the same cycle is legal.
        if (tq_get_o && alloc_q[tq_tag_i] && !(tq_free_o && (tq_tag_o == tq_tag_i))) begin
            err_d = 1'b1;
        end
        if (rsp_acc && !alloc_q[rsp_tag_i]) begin
            err_d = 1'b1;
        end
        if (tq_free_o) begin
            alloc_d[tq_tag_o] = 1'b0;
        end
        if (tq_get_o) begin
            alloc_d[tq_tag_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alloc_q <= '0;
            err_q   <= 1'b0;
        end else begin
            alloc_q <= alloc_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_inflight_tag_table.sv
// Directed bench for inflight_tag_table: issue, retire, stalls, back-pressure, tag reuse, error flag.
module tb_inflight_tag_table;

    localparam int NumTags   = 16;
    localparam int MetaWidth = 8;
    localparam int DataWidth = 32;
    localparam int TagWidth  = 4;

`ifdef INFLIGHT_TAG_TABLE_CHECK_EN
    localparam logic ErrExp = 1'b1;
`else
    localparam logic ErrExp = 1'b0;
`endif

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 tq_get_o;
    logic                 tq_valid_i;
    logic [TagWidth-1:0]  tq_tag_i;
    logic                 tq_free_o;
    logic [TagWidth-1:0]  tq_tag_o;
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [MetaWidth-1:0] req_meta_i;
    logic [DataWidth-1:0] req_data_i;
    logic                 iss_valid_o;
    logic                 iss_ready_i;
    logic [TagWidth-1:0]  iss_tag_o;
    logic [DataWidth-1:0] iss_data_o;
    logic                 rsp_valid_i;
    logic                 rsp_ready_o;
    logic [TagWidth-1:0]  rsp_tag_i;
    logic [DataWidth-1:0] rsp_data_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [MetaWidth-1:0] out_meta_o;
    logic [DataWidth-1:0] out_data_o;
    logic [4:0]           inflight_o;
    logic                 err_o;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk_i = ~clk_i;

    inflight_tag_table #(
        .NumTags  (NumTags),
        .MetaWidth(MetaWidth),
        .DataWidth(DataWidth)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .tq_get_o   (tq_get_o),
        .tq_valid_i (tq_valid_i),
        .tq_tag_i   (tq_tag_i),
        .tq_free_o  (tq_free_o),
        .tq_tag_o   (tq_tag_o),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_meta_i (req_meta_i),
        .req_data_i (req_data_i),
        .iss_valid_o(iss_valid_o),
        .iss_ready_i(iss_ready_i),
        .iss_tag_o  (iss_tag_o),
        .iss_data_o (iss_data_o),
        .rsp_valid_i(rsp_valid_i),
        .rsp_ready_o(rsp_ready_o),
        .rsp_tag_i  (rsp_tag_i),
        .rsp_data_i (rsp_data_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_meta_o (out_meta_o),
        .out_data_o (out_data_o),
        .inflight_o (inflight_o),
        .err_o      (err_o)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    int unsigned rsp_order [4] = '{2, 0, 3, 1};
    int unsigned meta_exp  [4] = '{8'h13, 8'h11, 8'h14, 8'h12};

    initial begin
        rst_i       = 1'b1;
        tq_valid_i  = 1'b0;
        tq_tag_i    = '0;
        req_valid_i = 1'b0;
        req_meta_i  = '0;
        req_data_i  = '0;
        iss_ready_i = 1'b0;
        rsp_valid_i = 1'b0;
        rsp_tag_i   = '0;
        rsp_data_i  = '0;
        out_ready_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        #1;
        check("rst_iss_valid", iss_valid_o, 0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_inflight", inflight_o, 0);
        check("rst_err", err_o, 0);
        check("rst_rsp_ready", rsp_ready_o, 1);
        check("rst_req_ready", req_ready_o, 0);
        check("rst_tq_free", tq_free_o, 0);

        // Four back-to-back requests, tags 0..3.
        iss_ready_i = 1'b1;
        tq_valid_i  = 1'b1;
        req_valid_i = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            tq_tag_i   = TagWidth'(i);
            req_meta_i = MetaWidth'(8'h11 + i);
            req_data_i = 32'hA000 + i;
            #1;
            check("iss_req_ready", req_ready_o, 1);
            check("iss_tq_get", tq_get_o, 1);
            step();
            check("iss_valid", iss_valid_o, 1);
            check("iss_tag", iss_tag_o, i);
            check("iss_data", iss_data_o, 32'hA000 + i);
            check("iss_inflight", inflight_o, i + 1);
        end
        req_valid_i = 1'b0;
        step();
        check("iss_drain_valid", iss_valid_o, 0);
        check("iss_inflight4", inflight_o, 4);

        // Out-of-order responses, retired back to back.
        out_ready_i = 1'b1;
        rsp_valid_i = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            rsp_tag_i  = TagWidth'(rsp_order[k]);
            rsp_data_i = 32'hB0 + k;
            #1;
            check("rsp_ready", rsp_ready_o, 1);
            check("rsp_free", tq_free_o, (k > 0) ? 1 : 0);
            if (k > 0) check("rsp_free_tag", tq_tag_o, rsp_order[k-1]);
            step();
            check("rsp_out_valid", out_valid_o, 1);
            check("rsp_out_meta", out_meta_o, meta_exp[k]);
            check("rsp_out_data", out_data_o, 32'hB0 + k);
        end
        rsp_valid_i = 1'b0;
        #1;
        check("rsp_last_free", tq_free_o, 1);
        check("rsp_last_free_tag", tq_tag_o, 1);
        step();
        check("rsp_drain_valid", out_valid_o, 0);
        check("rsp_inflight0", inflight_o, 0);

        // No free tags: requests stall.
        tq_valid_i  = 1'b0;
        req_valid_i = 1'b1;
        for (int unsigned c = 0; c < 5; c++) begin
            #1;
            check("stall_req_ready", req_ready_o, 0);
            check("stall_tq_get", tq_get_o, 0);
            step();
            check("stall_iss_valid", iss_valid_o, 0);
            check("stall_inflight", inflight_o, 0);
        end
        req_valid_i = 1'b0;

        // Output back-pressure on a pending response for tag 6.
        tq_valid_i  = 1'b1;
        tq_tag_i    = 4'd6;
        req_meta_i  = 8'h66;
        req_data_i  = 32'hA006;
        req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        step();
        out_ready_i = 1'b0;
        rsp_valid_i = 1'b1;
        rsp_tag_i   = 4'd6;
        rsp_data_i  = 32'hC6;
        step();
        rsp_valid_i = 1'b0;
        for (int unsigned c = 0; c < 3; c++) begin
            check("bp_out_valid", out_valid_o, 1);
            check("bp_out_meta", out_meta_o, 8'h66);
            check("bp_out_data", out_data_o, 32'hC6);
            check("bp_rsp_ready", rsp_ready_o, 0);
            check("bp_tq_free", tq_free_o, 0);
            check("bp_inflight", inflight_o, 1);
            step();
        end
        out_ready_i = 1'b1;
        #1;
        check("bp_free", tq_free_o, 1);
        check("bp_free_tag", tq_tag_o, 6);
        check("bp_rsp_ready_hs", rsp_ready_o, 1);
        step();
        check("bp_out_drain", out_valid_o, 0);
        check("bp_inflight0", inflight_o, 0);

        // Tag 5 reallocated in the same cycle it is freed.
        tq_tag_i    = 4'd5;
        req_meta_i  = 8'h55;
        req_data_i  = 32'hA005;
        req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        step();
        rsp_valid_i = 1'b1;
        rsp_tag_i   = 4'd5;
        rsp_data_i  = 32'hC5;
        step();
        rsp_valid_i = 1'b0;
        check("reuse_first_meta", out_meta_o, 8'h55);
        req_meta_i  = 8'h77;
        req_data_i  = 32'hA077;
        req_valid_i = 1'b1;
        #1;
        check("reuse_tq_get", tq_get_o, 1);
        check("reuse_tq_free", tq_free_o, 1);
        check("reuse_free_tag", tq_tag_o, 5);
        check("reuse_inflight_pre", inflight_o, 1);
        step();
        req_valid_i = 1'b0;
        check("reuse_inflight_post", inflight_o, 1);
        check("reuse_iss_tag", iss_tag_o, 5);
        check("reuse_iss_data", iss_data_o, 32'hA077);
        rsp_valid_i = 1'b1;
        rsp_data_i  = 32'hC7;
        step();
        rsp_valid_i = 1'b0;
        check("reuse_new_meta", out_meta_o, 8'h77);
        check("reuse_new_data", out_data_o, 32'hC7);
        step();
        check("reuse_inflight0", inflight_o, 0);
        check("reuse_err", err_o, 0);

        // Response for a tag that was never allocated.
        rsp_valid_i = 1'b1;
        rsp_tag_i   = 4'd9;
        rsp_data_i  = 32'hC9;
        step();
        rsp_valid_i = 1'b0;
        check("err_set", err_o, ErrExp);
        step();
        step();
        check("err_sticky", err_o, ErrExp);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("err_cleared", err_o, 0);
        check("err_rst_inflight", inflight_o, 0);
        check("err_rst_out_valid", out_valid_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inflight_tag_table.md
# inflight_tag_table

Bookkeeping stage directly downstream of `tag_queue`. Pulls a free tag for every incoming request, stores the request's metadata in a per-tag table, and forwards the request tagged. When the matching tagged response returns, it looks up the metadata, emits the response with it, and frees the tag back to `tag_queue` on the handshake that retires the response.

## Interface

Parameters:
- `NumTags`, 16: tags managed; must match the paired `tag_queue`; power of two ≥ 2.
- `MetaWidth`, 8: per-request metadata bits held in the table.
- `DataWidth`, 32: payload width on request and response paths.
- `TagWidth`, `$clog2(NumTags)`: derived; not to be overridden.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. Synchronous, active-high; one clock; all state resets on the rising edge where `rst_i`=1.
- `tq_get_o` out 1: get strobe to `tag_queue`.
- `tq_valid_i` in 1: `tag_queue` has a free tag.
- `tq_tag_i` in TagWidth: free tag offered.
- `tq_free_o` out 1: free strobe to `tag_queue`.
- `tq_tag_o` out TagWidth: tag being freed.
- `req_valid_i` / `req_ready_o` in/out 1: request handshake.
- `req_meta_i` in MetaWidth: metadata stored in the table.
- `req_data_i` in DataWidth: payload forwarded downstream.
- `iss_valid_o` / `iss_ready_i` out/in 1: issued request handshake.
- `iss_tag_o` out TagWidth: allocated tag.
- `iss_data_o` out DataWidth: forwarded payload.
- `rsp_valid_i` / `rsp_ready_o` in/out 1: tagged response in.
- `rsp_tag_i` in TagWidth: response tag.
- `rsp_data_i` in DataWidth: response payload.
- `out_valid_o` / `out_ready_i` out/in 1: retired response out.
- `out_meta_o` out MetaWidth: metadata looked up for the tag.
- `out_data_o` out DataWidth: response payload.
- `inflight_o` out `$clog2(NumTags+1)`: number of allocated tags.
- `err_o` out 1: sticky protocol error (see Configuration).

## Operation

- Issue path: one output register (`iss_*`).
  - `req_ready_o = tq_valid_i && (!iss_valid_o || iss_ready_i)`.
  - `tq_get_o = req_valid_i && req_ready_o`, a combinational accept.
  - On accept: `meta[tq_tag_i] <= req_meta_i`; `iss_tag_o <= tq_tag_i`; `iss_data_o <= req_data_i`; `iss_valid_o <= 1`.
  - Otherwise `iss_valid_o` clears when `iss_ready_i` is high.
- Response path: one output register (`out_*`).
  - `rsp_ready_o = !out_valid_o || out_ready_i`.
  - On accept: `out_meta_o <= meta[rsp_tag_i]`; `out_data_o <= rsp_data_i`; the held tag `<= rsp_tag_i`; `out_valid_o <= 1`.
- Free:
  - `tq_free_o = out_valid_o && out_ready_i`.
  - `tq_tag_o` = held tag, combinational.
  - Exactly one free per retired response. `tag_queue` has no back-pressure on free.
- Counter `inflight_o`:
  - +1 on `tq_get_o`, −1 on `tq_free_o`.
  - Both in the same cycle leaves it unchanged.
  - Never exceeds `NumTags`, never underflows under legal stimulus.
- Table: flop array `NumTags×MetaWidth`, one write port (issue) and one read port (response), no reset on contents.
- Same-cycle alloc of tag T and free of tag T: legal. The read completed a cycle earlier, so the new write is safe.
- Same-cycle alloc of T and response accept for T: illegal stimulus; caught only with the check enabled.

## Timing

- Reset values: `iss_valid_o`=0, `out_valid_o`=0, `inflight_o`=0, `err_o`=0. `tq_get_o`, `tq_free_o`, `req_ready_o` follow from these.
- `rsp_ready_o`=1 after reset. Data, tag and meta outputs are don't-care while their valid is low.
- Request to `iss_valid_o`: 1 cycle. Full throughput of one request per cycle while `iss_ready_i`=1 and `tq_valid_i`=1.
- Response to `out_valid_o`: 1 cycle. Full throughput of one response per cycle.
- Free strobe: same cycle as the `out` handshake. The tag is reusable by `tag_queue` from the next cycle.
- Handshake rules: valid outputs never drop without ready; data is stable while valid and not ready.
- `tq_valid_i`=0 (all tags in flight): `req_ready_o`=0. Requests stall; the response path is unaffected.
- Reset mid-operation: in-flight entries are discarded. The paired `tag_queue` must be reset in the same cycle.

## Configuration

- `INFLIGHT_TAG_TABLE_CHECK_EN` defined: adds an `NumTags`-bit allocated bitmap, set on alloc and cleared on free. `err_o` sets, sticky until reset, on either of:
  - an alloc of an already-set tag;
  - a response accept whose tag bit is clear.
- Undefined: no bitmap; `err_o` tied to 0.

## Test plan

- Reset, then 4 requests (meta 0x11..0x14) with `iss_ready_i`=1 and tags 0..3 offered → `iss_tag_o` 0,1,2,3 on consecutive cycles, each 1 cycle after accept; `inflight_o`=4.
- Responses for tags 2,0,3,1 with `out_ready_i`=1 → `out_meta_o` 0x13,0x11,0x14,0x12; `tq_free_o` pulses with `tq_tag_o` 2,0,3,1; `inflight_o` returns to 0.
- `tq_valid_i`=0 with `req_valid_i`=1 for 5 cycles → `req_ready_o`=0 and `tq_get_o`=0 throughout; no issue.
- `out_ready_i`=0 for 3 cycles with a pending response → `out_*` held stable; `rsp_ready_o`=0; `tq_free_o`=0 until the handshake.
- Alloc of tag 5 in the same cycle as freeing tag 5 → `inflight_o` unchanged; the new meta is returned for the later response.
- With `INFLIGHT_TAG_TABLE_CHECK_EN`, a response for never-allocated tag 9 → `err_o`=1 the next cycle, held until `rst_i`.
